// File: rtl/pps_pkg.sv
// Shared definitions for the 1PPS generator.
//   pps_state_e : generator FSM states (idle, waiting for reference alignment, running)
//   C_REF_LAT   : clocks from a pps_ref rising edge to the counter load it causes
//   clamp_cfg   : limits a 32-bit configuration value to an upper bound
package pps_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StAlignWait = 2'd1,
        StRun       = 2'd2
    } pps_state_e;

    // 2 synchronizer flops + 1 registered edge detect
    localparam int unsigned C_REF_LAT = 3;

    function automatic logic [31:0] clamp_cfg(input logic [31:0] value, input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Synchronizes the asynchronous external reference pulse into the core clock domain and
// produces a single-cycle strobe on its rising edge, three clocks after the input edge.
// Only built when PPS_GENERATOR_ALIGN_EN is defined.
// Ports:
//   clk_i   core clock
//   rst_i   synchronous reset, active-high
//   async_i asynchronous reference pulse
//   rise_o  registered single-cycle rising-edge strobe
`ifdef PPS_GENERATOR_ALIGN_EN
module pps_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule
`endif

// File: rtl/pps_generator.sv
// Local 1PPS generator: a free-running one-second counter with programmable pulse phase and
// width, plus a running count of emitted seconds. Configuration is shadowed and only takes
// effect at a second boundary, so a period is never glitched by a mid-second change.
// Optional macro PPS_GENERATOR_ALIGN_EN adds alignment of the counter to an external reference.
// Ports:
//   clk_i              core clock
//   rst_i              synchronous reset, active-high
//   enable_i           1 = run generator, 0 = idle
//   cfg_phase_i        counter value at which the pulse is launched (clamped to P-1)
//   cfg_pulse_width_i  pulse high time in clocks (clamped to P-1)
//   pps_out_o          registered 1PPS output
//   pps_tick_o         single-cycle strobe coincident with the start of each pulse
//   stat_seconds_o     number of ticks since reset, wrapping
//   stat_running_o     1 while the generator is running
//   pps_ref_i          asynchronous external reference (macro build only)
//   stat_ref_phase_o   counter value seen at the last reference edge (macro build only)
module pps_generator
    import pps_pkg::*;
#(
    parameter int unsigned C_CLOCK_FREQUENCY = 125000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [31:0] cfg_phase_i,
    input  logic [31:0] cfg_pulse_width_i,
    output logic        pps_out_o,
    output logic        pps_tick_o,
    output logic [31:0] stat_seconds_o,
    output logic        stat_running_o
`ifdef PPS_GENERATOR_ALIGN_EN
    ,
    input  logic        pps_ref_i,
    output logic [31:0] stat_ref_phase_o
`endif
);

    localparam int unsigned W      = $clog2(C_CLOCK_FREQUENCY);
    localparam logic [31:0] CfgMax = 32'(C_CLOCK_FREQUENCY - 1);
    localparam logic [W-1:0] CntMax = W'(C_CLOCK_FREQUENCY - 1);

    pps_state_e   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] phase_q, phase_d;
    logic [W-1:0] width_q, width_d;
    // High cycles still owed after the current one; lets a pulse run across the wrap
    logic [W-1:0] rem_q, rem_d;
    logic         pps_out_q, pps_out_d;
    logic         pps_tick_q, pps_tick_d;
    logic [31:0]  seconds_q, seconds_d;

    logic [W-1:0] phase_cfg;
    logic [W-1:0] width_cfg;

    // Clamped values fit in W bits, so the truncation is lossless
    assign phase_cfg = W'(clamp_cfg(cfg_phase_i, CfgMax));
    assign width_cfg = W'(clamp_cfg(cfg_pulse_width_i, CfgMax));

`ifdef PPS_GENERATOR_ALIGN_EN
    logic        ref_rise;
    logic [31:0] ref_phase_q, ref_phase_d;

    pps_edge_sync u_edge_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (pps_ref_i),
        .rise_o  (ref_rise)
    );
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        width_d    = width_q;
        rem_d      = rem_q;
        pps_out_d  = 1'b0;
        pps_tick_d = 1'b0;
        seconds_d  = seconds_q;
`ifdef PPS_GENERATOR_ALIGN_EN
        ref_phase_d = ref_phase_q;
`endif

        if (!enable_i) begin
            // Disable truncates any pulse in flight; the second count is kept
            state_d = StIdle;
            cnt_d   = '0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
`ifdef PPS_GENERATOR_ALIGN_EN
                    state_d = StAlignWait;
`else
                    state_d = StRun;
                    phase_d = phase_cfg;
                    width_d = width_cfg;
`endif
                end

                StAlignWait: begin
`ifdef PPS_GENERATOR_ALIGN_EN
                    cnt_d = '0;
                    if (ref_rise) begin
                        // Counter starts where it would be had it been zeroed at the ref edge
                        state_d = StRun;
                        cnt_d   = W'(C_REF_LAT);
                        phase_d = phase_cfg;
                        width_d = width_cfg;
                    end
`else
                    state_d = StIdle;
`endif
                end

                StRun: begin
                    if (cnt_q == CntMax) begin
                        cnt_d   = '0;
                        phase_d = phase_cfg;
                        width_d = width_cfg;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end

                    if (cnt_q == phase_q) begin
                        pps_tick_d = 1'b1;
                        seconds_d  = seconds_q + 32'd1;
                        if (width_q != '0) begin
                            pps_out_d = 1'b1;
                            rem_d     = width_q - W'(1);
                        end else if (rem_q != '0) begin
                            pps_out_d = 1'b1;
                            rem_d     = rem_q - W'(1);
                        end
                    end else if (rem_q != '0) begin
                        pps_out_d = 1'b1;
                        rem_d     = rem_q - W'(1);
                    end

`ifdef PPS_GENERATOR_ALIGN_EN
                    // The match above uses the pre-load count, so a coincident ref edge
                    // still emits this second's pulse
                    if (ref_rise) begin
                        ref_phase_d = 32'(cnt_q);
                        cnt_d       = W'(C_REF_LAT);
                    end
`endif
                end

                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            phase_q    <= '0;
            width_q    <= '0;
            rem_q      <= '0;
            pps_out_q  <= 1'b0;
            pps_tick_q <= 1'b0;
            seconds_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            width_q    <= width_d;
            rem_q      <= rem_d;
            pps_out_q  <= pps_out_d;
            pps_tick_q <= pps_tick_d;
            seconds_q  <= seconds_d;
        end
    end

`ifdef PPS_GENERATOR_ALIGN_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ref_phase_q <= '0;
        end else begin
            ref_phase_q <= ref_phase_d;
        end
    end

    assign stat_ref_phase_o = ref_phase_q;
`endif

    assign pps_out_o      = pps_out_q;
    assign pps_tick_o     = pps_tick_q;
    assign stat_seconds_o = seconds_q;
    assign stat_running_o = (state_q == StRun);

endmodule
